// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch flush, dmem handshake + watchdog.
// Optional macro PIPE_PERF_EN adds stall_cycles_o (saturating count of PC-stalled cycles).
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        IDEX_MemRead_i,
  input  logic [4:0]  IDEX_rt_i,
  input  logic [4:0]  IFID_rs_i,
  input  logic [4:0]  IFID_rt_i,
  input  logic        branch_taken_i,
  input  logic        EXMEM_MemRead_i,
  input  logic        EXMEM_MemWrite_i,
  input  logic        dmem_ack_i,
  output logic        dmem_req_o,
  output logic        PC_en_o,
  output logic        IFID_en_o,
  output logic        IDEX_en_o,
  output logic        EXMEM_en_o,
  output logic        MEMWB_en_o,
  output logic        IFID_flush_o,
  output logic        IDEX_bubble_o,
  output logic        MEMWB_bubble_o,
`ifdef PIPE_PERF_EN
  output logic [31:0] stall_cycles_o,
`endif
  output logic        timeout_o
);

  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERROR = 2'd2} state_t;

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     r_state;
  logic [7:0] r_wait_cnt;
  logic       r_timeout;
  logic       w_memop;
  logic       w_loaduse;

  assign w_memop   = EXMEM_MemRead_i | EXMEM_MemWrite_i;
  assign w_loaduse = IDEX_MemRead_i && (IDEX_rt_i != 5'd0) &&
                     ((IDEX_rt_i == IFID_rs_i) || (IDEX_rt_i == IFID_rt_i));
  assign timeout_o = r_timeout;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= RUN;
      r_wait_cnt <= 8'd0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_memop && !dmem_ack_i) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= 8'd0;
          end
        end
        MEM_WAIT: begin
          r_wait_cnt <= r_wait_cnt + 8'd1;
          // an ack arriving on the last allowed cycle still completes the access
          if (dmem_ack_i) begin
            r_state <= RUN;
          end else if (r_wait_cnt == TO_LAST) begin
            r_state   <= ERROR;
            r_timeout <= 1'b1;
          end
        end
        ERROR:   r_state <= ERROR;
        default: r_state <= RUN;
      endcase
    end
  end

  always_comb begin
    dmem_req_o     = 1'b0;
    PC_en_o        = 1'b1;
    IFID_en_o      = 1'b1;
    IDEX_en_o      = 1'b1;
    EXMEM_en_o     = 1'b1;
    MEMWB_en_o     = 1'b1;
    IFID_flush_o   = 1'b0;
    IDEX_bubble_o  = 1'b0;
    MEMWB_bubble_o = 1'b0;
    if (rst_i) begin
      IFID_flush_o   = 1'b1;
      IDEX_bubble_o  = 1'b1;
      MEMWB_bubble_o = 1'b1;
    end else if (r_state == ERROR) begin
      PC_en_o    = 1'b0;
      IFID_en_o  = 1'b0;
      IDEX_en_o  = 1'b0;
      EXMEM_en_o = 1'b0;
      MEMWB_en_o = 1'b0;
    end else if (r_state == MEM_WAIT) begin
      dmem_req_o = 1'b1;
      if (!dmem_ack_i) begin
        PC_en_o        = 1'b0;
        IFID_en_o      = 1'b0;
        IDEX_en_o      = 1'b0;
        EXMEM_en_o     = 1'b0;
        MEMWB_bubble_o = 1'b1;
      end
    end else if (w_memop && !dmem_ack_i) begin
      // freeze everything upstream of MEM; MEMWB drains a bubble
      dmem_req_o     = 1'b1;
      PC_en_o        = 1'b0;
      IFID_en_o      = 1'b0;
      IDEX_en_o      = 1'b0;
      EXMEM_en_o     = 1'b0;
      MEMWB_bubble_o = 1'b1;
    end else begin
      dmem_req_o = w_memop;
      if (w_loaduse) begin
        PC_en_o       = 1'b0;
        IFID_en_o     = 1'b0;
        IDEX_bubble_o = 1'b1;
      end else if (branch_taken_i) begin
        IFID_flush_o = 1'b1;
      end
    end
  end

`ifdef PIPE_PERF_EN
  logic [31:0] r_stall_cnt;
  assign stall_cycles_o = r_stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_stall_cnt <= 32'd0;
    else if (!PC_en_o && (r_stall_cnt != 32'hFFFF_FFFF))
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: per-cycle expected outputs from a behavioural model, checked by a monitor.
module tb_pipe_ctrl;
  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, idex_mr, br, mr, mw, ack;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;
  logic       req, pc_en, ifid_en, idex_en, exmem_en, memwb_en, flush, idb, mwb, tmo;
  logic [31:0] stall_act;

  pipe_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .IDEX_MemRead_i(idex_mr), .IDEX_rt_i(idex_rt),
    .IFID_rs_i(ifid_rs), .IFID_rt_i(ifid_rt),
    .branch_taken_i(br), .EXMEM_MemRead_i(mr), .EXMEM_MemWrite_i(mw),
    .dmem_ack_i(ack), .dmem_req_o(req),
    .PC_en_o(pc_en), .IFID_en_o(ifid_en), .IDEX_en_o(idex_en),
    .EXMEM_en_o(exmem_en), .MEMWB_en_o(memwb_en),
    .IFID_flush_o(flush), .IDEX_bubble_o(idb), .MEMWB_bubble_o(mwb),
`ifdef PIPE_PERF_EN
    .stall_cycles_o(stall_act),
`endif
    .timeout_o(tmo)
  );
`ifndef PIPE_PERF_EN
  assign stall_act = 32'd0;
`endif

  // {req, en[PC,IFID,IDEX,EXMEM,MEMWB], flush, idex_bubble, memwb_bubble, timeout}
  typedef struct packed {
    logic [9:0]  bits;
    logic [31:0] stall;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // model: are we waiting on memory, how many wait cycles elapsed, are we dead
  bit waiting = 0;
  int waited  = 0;
  bit dead    = 0;
  bit to_flag = 0;
  int stalls  = 0;

  function automatic logic [9:0] model_out();
    bit memop, lu;
    memop = mr | mw;
    lu    = idex_mr && idex_rt != 0 && (idex_rt == ifid_rs || idex_rt == ifid_rt);
    if (rst)                  return {1'b0, 5'b11111, 3'b111, to_flag};
    if (dead)                 return {1'b0, 5'b00000, 3'b000, to_flag};
    if (waiting && ack)       return {1'b1, 5'b11111, 3'b000, to_flag};
    if (waiting || (memop && !ack))
                              return {1'b1, 5'b00001, 3'b001, to_flag};
    if (lu)                   return {memop, 5'b00111, 3'b010, to_flag};
    if (br)                   return {memop, 5'b11111, 3'b100, to_flag};
    return {memop, 5'b11111, 3'b000, to_flag};
  endfunction

  task automatic step(input logic r, input logic imr, input logic [4:0] irt, input logic [4:0] rs,
                      input logic [4:0] rt, input logic b, input logic m_r, input logic m_w,
                      input logic a);
    exp_t e;
    @(posedge clk); #1;
    rst = r; idex_mr = imr; idex_rt = irt; ifid_rs = rs; ifid_rt = rt;
    br = b; mr = m_r; mw = m_w; ack = a;
    e.bits  = model_out();
    e.stall = stalls;
    exp_q.push_back(e);
    // advance the model across the coming clock edge
    if (r) begin
      waiting = 0; waited = 0; dead = 0; to_flag = 0; stalls = 0;
    end else begin
      if (e.bits[8] == 1'b0) stalls++;
      if (dead) begin
      end else if (waiting) begin
        if (a) waiting = 0;
        else if (waited == TO - 1) begin waiting = 0; dead = 1; to_flag = 1; end
        else waited++;
      end else if ((m_r | m_w) && !a) begin
        waiting = 1; waited = 0;
      end
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [9:0] act;
      e   = exp_q.pop_front();
      act = {req, pc_en, ifid_en, idex_en, exmem_en, memwb_en, flush, idb, mwb, tmo};
      n_vec++;
      if (act !== e.bits) begin
        n_bad++;
        $display("FAIL ctrl_outputs t=%0t got=%b want=%b (req,en5,flush,idb,mwb,to)", $time, act, e.bits);
      end
`ifdef PIPE_PERF_EN
      n_vec++;
      if (stall_act !== e.stall) begin
        n_bad++;
        $display("FAIL stall_cycles t=%0t got=%0d want=%0d", $time, stall_act, e.stall);
      end
`endif
    end
  end

  initial begin
    rst = 1; idex_mr = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
    br = 0; mr = 0; mw = 0; ack = 0;
    // reset, then zero-wait load
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    step(0, 0, 0, 0, 0, 0, 1, 0, 1);
    // store acked on the 4th cycle
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle();
    // load-use on rs, then on rt, then rt==0 no stall
    step(0, 1, 5, 5, 7, 0, 0, 0, 0);
    idle();
    step(0, 1, 9, 1, 9, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    // branch suppressed by load-use, then taken alone
    step(0, 1, 3, 3, 0, 1, 0, 0, 0);
    step(0, 0, 3, 3, 0, 1, 0, 0, 0);
    // back-to-back memops: ack then immediate re-entry
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 1);
    // reset in the middle of a wait
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);
    idle();
    // watchdog: no ack ever, then ack on the very last wait cycle
    for (int i = 0; i < 8; i++) step(0, 1, 2, 2, 2, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TO; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 1);
    idle();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic r;
      r = ($urandom_range(63) == 0) || (dead && $urandom_range(3) == 0);
      step(r, 1'($urandom_range(1)), 5'($urandom_range(3)), 5'($urandom_range(3)),
           5'($urandom_range(3)), 1'($urandom_range(3) == 0),
           1'($urandom_range(5) == 0), 1'($urandom_range(5) == 0),
           1'($urandom_range(1)));
    end
    idle();
    @(posedge clk);
    @(posedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
